// File: rtl/heap_pkg.sv
// Shared widths, RAM mode encodings and allocator state encodings for the cell heap.
// The RAM model and the allocator both import this package.
package heap_pkg;

    localparam int ADDRESS_BITS = 16;
    localparam int DATA_BITS    = 16;
    localparam int HEAP_BITS    = 8;

    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FREE_WR  = 3'd1,
        POP_RD   = 3'd2,
        POP_WAIT = 3'd3,
        DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/heap_if.sv
// Processor request bus and heap-memory bus of the cell allocator, bundled together.
// The master side is the allocator. The slave side is the requester together with the RAM.
interface heap_if #(
    parameter int addr_bits = heap_pkg::ADDRESS_BITS,
    parameter int data_bits = heap_pkg::DATA_BITS
);
    logic                 alloc;
    logic                 free;
    logic [addr_bits-1:0] free_address;
    logic                 finished;
    logic [addr_bits-1:0] alloc_address;

    logic [addr_bits-1:0] address;
    logic                 read_write_mode;
    logic [data_bits-1:0] data_in;
    logic [data_bits-1:0] data_out;

    modport master (
        input  alloc, free, free_address, data_out,
        output finished, alloc_address, address, read_write_mode, data_in
    );

    modport slave (
        output alloc, free, free_address, data_out,
        input  finished, alloc_address, address, read_write_mode, data_in
    );
endinterface

// File: rtl/heap_ram.sv
// Single-port synchronous heap RAM: a write happens when the mode is 1.
// A read returns the word at the sampled address on the next clock edge.
module heap_ram
    import heap_pkg::*;
#(
    parameter int addr_bits = ADDRESS_BITS,
    parameter int data_bits = DATA_BITS
) (
    input  logic                 clk,
    input  logic [addr_bits-1:0] address,
    input  logic                 read_write_mode,
    input  logic [data_bits-1:0] data_in,
    output logic [data_bits-1:0] data_out
);

    logic [data_bits-1:0] mem_q [2**addr_bits];
    logic [data_bits-1:0] data_out_q;

    // A read issued in the same cycle as a write returns the old word.
    always_ff @(posedge clk) begin
        if (read_write_mode == RAM_WRITE) begin
            mem_q[address] <= data_in;
        end
        data_out_q <= mem_q[address];
    end

    assign data_out = data_out_q;

endmodule

// File: rtl/heap.sv
// Fixed-size cell allocator. Cells are handed out by bumping heap_end until it saturates.
// After that, cells are popped from a LIFO free list that is threaded through the heap RAM.
module heap
    import heap_pkg::*;
#(
    parameter int addr_bits = ADDRESS_BITS,
    parameter int data_bits = DATA_BITS,
    parameter int heap_bits = HEAP_BITS
) (
    input  logic  clk,
    input  logic  reset,
    heap_if.master bus
);

    localparam logic [heap_bits-1:0] HEAP_MAX = '1;

    state_t               state_q, state_d;
    logic [heap_bits-1:0] heap_end_q, heap_end_d;
    logic [heap_bits-1:0] heap_free_q, heap_free_d;
    logic [heap_bits:0]   free_count_q, free_count_d;
    logic                 finished_q, finished_d;
    logic [addr_bits-1:0] alloc_address_q, alloc_address_d;
    logic [addr_bits-1:0] address_q, address_d;
    logic [data_bits-1:0] data_in_q, data_in_d;
    logic                 rw_mode_q, rw_mode_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            heap_end_q      <= '0;
            heap_free_q     <= '0;
            free_count_q    <= '0;
            finished_q      <= 1'b0;
            alloc_address_q <= '0;
            address_q       <= '0;
            data_in_q       <= '0;
            rw_mode_q       <= RAM_READ;
        end else begin
            state_q         <= state_d;
            heap_end_q      <= heap_end_d;
            heap_free_q     <= heap_free_d;
            free_count_q    <= free_count_d;
            finished_q      <= finished_d;
            alloc_address_q <= alloc_address_d;
            address_q       <= address_d;
            data_in_q       <= data_in_d;
            rw_mode_q       <= rw_mode_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        heap_end_d      = heap_end_q;
        heap_free_d     = heap_free_q;
        free_count_d    = free_count_q;
        alloc_address_d = alloc_address_q;
        address_d       = address_q;
        data_in_d       = data_in_q;
        rw_mode_d       = rw_mode_q;

        case (state_q)
            IDLE: begin
                if (bus.alloc) begin
                    if (heap_end_q != HEAP_MAX) begin
                        alloc_address_d = addr_bits'(heap_end_q);
                        heap_end_d      = heap_end_q + 1'b1;
                        state_d         = DONE;
                    end else if (free_count_q != '0) begin
                        address_d       = addr_bits'(heap_free_q);
                        rw_mode_d       = RAM_READ;
                        alloc_address_d = addr_bits'(heap_free_q);
                        state_d         = POP_RD;
                    end else begin
                        // Exhausted: report all-ones and leave the heap untouched.
                        alloc_address_d = '1;
                        state_d         = DONE;
                    end
                end else if (bus.free) begin
                    address_d = bus.free_address;
                    data_in_d = data_bits'(heap_free_q);
                    rw_mode_d = RAM_WRITE;
                    state_d   = FREE_WR;
                end
            end
            FREE_WR: begin
                // address_q still holds the latched freeAddress.
                heap_free_d  = address_q[heap_bits-1:0];
                free_count_d = free_count_q + 1'b1;
                rw_mode_d    = RAM_READ;
                state_d      = DONE;
            end
            POP_RD: begin
                state_d = POP_WAIT;
            end
            POP_WAIT: begin
                heap_free_d  = bus.data_out[heap_bits-1:0];
                free_count_d = free_count_q - 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                if (!bus.alloc && !bus.free) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        finished_d = (state_d == DONE);
    end

    generate
        if (data_bits > heap_bits) begin : g_unused
            logic unused_data;
            assign unused_data = ^bus.data_out[data_bits-1:heap_bits];
        end
    endgenerate

    assign bus.finished        = finished_q;
    assign bus.alloc_address   = alloc_address_q;
    assign bus.address         = address_q;
    assign bus.data_in         = data_in_q;
    assign bus.read_write_mode = rw_mode_q;

endmodule

// File: tb/tb_heap.sv
// Directed bench for the cell allocator, wired to the heap RAM.
// It checks request latency, allocator registers and the free-list words held in RAM.
module tb_heap;
    import heap_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    heap_if #(.addr_bits(16), .data_bits(16)) bus ();

    heap #(.addr_bits(16), .data_bits(16), .heap_bits(8)) heap0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    heap_ram #(.addr_bits(16), .data_bits(16)) ram0 (
        .clk             (clk),
        .address         (bus.address),
        .read_write_mode (bus.read_write_mode),
        .data_in         (bus.data_in),
        .data_out        (bus.data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue a request, wait for finished, drop the request and wait for the return to IDLE.
    task automatic req(input logic a, input logic f, input logic [15:0] fa,
                       output logic [15:0] got, output int lat, output logic rw1);
        @(negedge clk);
        bus.alloc        = a;
        bus.free         = f;
        bus.free_address = fa;
        lat = 0;
        rw1 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) rw1 = bus.read_write_mode;
            if (bus.finished) begin
                lat = c;
                break;
            end
        end
        check("req_finished", 32'(lat != 0), 32'd1);
        got = bus.alloc_address;
        bus.alloc = 1'b0;
        bus.free  = 1'b0;
        @(posedge clk);
        #1;
        check("finished_drop", 32'(bus.finished), 32'd0);
        $display("req alloc=%0b free=%0b fa=%0h -> alloc_address=%0h lat=%0d heap_end=%0h heap_free=%0h count=%0d",
                 a, f, fa, got, lat, heap0.heap_end_q, heap0.heap_free_q, heap0.free_count_q);
    endtask

    logic [15:0] got;
    int          lat;
    logic        rw1;

    initial begin
        checks = 0;
        errors = 0;
        clk = 1'b0;
        reset = 1'b0;
        bus.alloc = 1'b0;
        bus.free = 1'b0;
        bus.free_address = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_finished", 32'(bus.finished), 32'd0);
        check("rst_heap_end", 32'(heap0.heap_end_q), 32'd0);
        check("rst_count", 32'(heap0.free_count_q), 32'd0);
        check("rst_rw", 32'(bus.read_write_mode), 32'd0);
        check("rst_alloc_addr", 32'(bus.alloc_address), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // 1: first bump allocation
        req(1'b1, 1'b0, 16'h0, got, lat, rw1);
        check("s1_addr", 32'(got), 32'h0);
        check("s1_lat", 32'(lat), 32'd1);
        check("s1_heap_end", 32'(heap0.heap_end_q), 32'h1);

        // 2: free cell 0
        req(1'b0, 1'b1, 16'h0, got, lat, rw1);
        check("s2_lat", 32'(lat), 32'd2);
        check("s2_rw_high", 32'(rw1), 32'd1);
        check("s2_rw_low", 32'(bus.read_write_mode), 32'd0);
        check("s2_heap_free", 32'(heap0.heap_free_q), 32'h0);
        check("s2_heap_end", 32'(heap0.heap_end_q), 32'h1);
        check("s2_count", 32'(heap0.free_count_q), 32'd1);

        // 3: bump is preferred over the free list
        req(1'b1, 1'b0, 16'h0, got, lat, rw1);
        check("s3_addr1", 32'(got), 32'h1);
        req(1'b1, 1'b0, 16'h0, got, lat, rw1);
        check("s3_addr2", 32'(got), 32'h2);
        check("s3_heap_end", 32'(heap0.heap_end_q), 32'h3);
        check("s3_heap_free", 32'(heap0.heap_free_q), 32'h0);

        // 4: free 1 then 2, threading the list through RAM
        req(1'b0, 1'b1, 16'h1, got, lat, rw1);
        check("s4_heap_free1", 32'(heap0.heap_free_q), 32'h1);
        check("s4_ram1_a", 32'(ram0.mem_q[1]), 32'h0);
        req(1'b0, 1'b1, 16'h2, got, lat, rw1);
        check("s4_heap_free2", 32'(heap0.heap_free_q), 32'h2);
        check("s4_ram2", 32'(ram0.mem_q[2]), 32'h1);
        check("s4_ram1_b", 32'(ram0.mem_q[1]), 32'h0);
        check("s4_heap_end", 32'(heap0.heap_end_q), 32'h3);
        check("s4_count", 32'(heap0.free_count_q), 32'd3);

        // 5: bump up to saturation, then pop the list head
        for (int i = 3; i < 255; i++) begin
            req(1'b1, 1'b0, 16'h0, got, lat, rw1);
            check("s5_bump", 32'(got), 32'(i));
        end
        check("s5_heap_end_max", 32'(heap0.heap_end_q), 32'hFF);
        req(1'b1, 1'b0, 16'h0, got, lat, rw1);
        check("s5_pop_addr", 32'(got), 32'h2);
        check("s5_pop_lat", 32'(lat), 32'd3);
        check("s5_heap_free", 32'(heap0.heap_free_q), 32'h1);
        check("s5_heap_end", 32'(heap0.heap_end_q), 32'hFF);
        check("s5_ram1", 32'(ram0.mem_q[1]), 32'h0);
        check("s5_count", 32'(heap0.free_count_q), 32'd2);

        // 6: drain the list, including cell 0, then hit exhaustion
        req(1'b1, 1'b0, 16'h0, got, lat, rw1);
        check("s6_pop1", 32'(got), 32'h1);
        check("s6_heap_free_a", 32'(heap0.heap_free_q), 32'h0);
        req(1'b1, 1'b0, 16'h0, got, lat, rw1);
        check("s6_pop0", 32'(got), 32'h0);
        check("s6_count", 32'(heap0.free_count_q), 32'd0);
        req(1'b1, 1'b0, 16'h0, got, lat, rw1);
        check("s6_exhausted", 32'(got), 32'hFFFF);
        check("s6_ex_lat", 32'(lat), 32'd1);
        check("s6_heap_end", 32'(heap0.heap_end_q), 32'hFF);
        check("s6_count_b", 32'(heap0.free_count_q), 32'd0);
        check("s6_heap_free_b", 32'(heap0.heap_free_q), 32'h0);

        // 7: reset asserted while a pop waits on the RAM
        req(1'b0, 1'b1, 16'h7, got, lat, rw1);
        check("s7_heap_free", 32'(heap0.heap_free_q), 32'h7);
        check("s7_ram7", 32'(ram0.mem_q[7]), 32'h0);
        @(negedge clk);
        bus.alloc = 1'b1;
        @(posedge clk);
        #1;
        check("s7_pop_rd", 32'(heap0.state_q), 32'(POP_RD));
        @(posedge clk);
        #1;
        check("s7_pop_wait", 32'(heap0.state_q), 32'(POP_WAIT));
        reset = 1'b0;
        #1;
        check("s7_state", 32'(heap0.state_q), 32'(IDLE));
        check("s7_finished", 32'(bus.finished), 32'd0);
        check("s7_heap_end", 32'(heap0.heap_end_q), 32'h0);
        check("s7_heap_free_r", 32'(heap0.heap_free_q), 32'h0);
        check("s7_count", 32'(heap0.free_count_q), 32'd0);
        check("s7_address", 32'(bus.address), 32'h0);
        check("s7_alloc_addr", 32'(bus.alloc_address), 32'h0);
        bus.alloc = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req(1'b1, 1'b0, 16'h0, got, lat, rw1);
        check("s7_post_alloc", 32'(got), 32'h0);
        check("s7_post_end", 32'(heap0.heap_end_q), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
